// File: rtl/frame_rx_pkg.sv
`default_nettype none
// frame_rx_pkg: shared state encoding and CRC-8 constants for the frame receiver.
package frame_rx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    SIZE    = 3'd2,
    DATA    = 3'd3,
    CRC     = 3'd4,
    STOP    = 3'd5,
    DELIVER = 3'd6
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // One MSB-first step of the CRC-8 shift register.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    crc8_step = {crc[6:0], 1'b0} ^ ((crc[7] ^ bit_in) ? CRC8_POLY : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc8_serial.sv
`default_nettype none
// crc8_serial: bit-serial CRC-8 accumulator, one bit per enable.
module crc8_serial
  import frame_rx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc <= CRC8_INIT;
    end else if (clear) begin
      crc <= CRC8_INIT;
    end else if (en) begin
      crc <= crc8_step(crc, bit_in);
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_rx_buffered.sv
`default_nettype none
// frame_rx_buffered: oversampled frame receiver; payload is released only after CRC and stop pass.
// Optional bit stuffing is built when FRAME_RX_STUFF_EN is defined.
module frame_rx_buffered
  import frame_rx_pkg::*;
#(
  parameter int MAX_BYTES = 16,
  parameter int FS_W      = 4,
  parameter int BAUD_W    = 8,
  parameter int NOISE_TOL = 2,
  parameter int STUFF_RUN = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RX,
  input  logic [BAUD_W-1:0] baudrate,
  input  logic              out_ready,
  output logic              dr,
  output logic [7:0]        dataout,
  output logic              frame_done,
  output logic              nf,
  output logic              over,
  output logic              fe,
  output logic              crc_err,
  output logic              busy
);

  localparam int PTR_W = $clog2(MAX_BYTES + 1);
  localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int BIT_W = $clog2(FS_W + 8);
  localparam logic [BAUD_W-1:0] BAUD_MIN = BAUD_W'(3);
  localparam logic [BAUD_W:0]   TOL      = (BAUD_W + 1)'(NOISE_TOL);
  localparam logic [PTR_W-1:0]  PTR_MAX  = PTR_W'(MAX_BYTES);

  if (MAX_BYTES < 1 || MAX_BYTES > 256 || STUFF_RUN < 1) begin : g_param_check
    $error("frame_rx_buffered: MAX_BYTES must be 1..256 and STUFF_RUN >= 1");
  end

  state_t            state, state_nx;
  logic              rx_meta, rx_s;
  logic [BAUD_W-1:0] bd, timer, ones;
  logic [BIT_W-1:0]  bit_cnt;
  logic [FS_W-1:0]   n_size, byte_cnt, size_next;
  logic [7:0]        shreg, byte_next, crc;
  logic [PTR_W-1:0]  wptr, rptr;
  logic [7:0]        mem [MAX_BYTES];
  logic [BAUD_W:0]   ones_all, zeros_all, minority;
  logic              sampling, bit_end, bit_val, noisy, take, byte_end, wr_en;
  logic              is_stuff, stuff_bad;

  // The sample landing on timer==bd-1 is part of the vote.
  assign sampling  = (state != IDLE) && (state != DELIVER);
  assign ones_all  = {1'b0, ones} + {{BAUD_W{1'b0}}, rx_s};
  assign zeros_all = {1'b0, bd} - ones_all;
  assign minority  = (ones_all < zeros_all) ? ones_all : zeros_all;
  assign bit_end   = sampling && (timer == bd - BAUD_W'(1));
  assign bit_val   = {ones_all, 1'b0} > {2'b00, bd};
  assign noisy     = minority > TOL;
  assign take      = bit_end && !is_stuff;
  assign byte_end  = take && ((state == DATA) || (state == CRC)) && (bit_cnt == BIT_W'(7));
  assign size_next = (n_size << 1) | FS_W'(bit_val);
  assign byte_next = {shreg[6:0], bit_val};
  assign wr_en     = byte_end && (state == DATA) && (wptr != PTR_MAX);
  assign busy      = (state != IDLE);

`ifdef FRAME_RX_STUFF_EN
  localparam int RUN_W = $clog2(STUFF_RUN + 1);
  logic [RUN_W-1:0] run;
  logic             last_bit;
  logic             stuffable;

  assign stuffable = (state == SIZE) || (state == DATA) || (state == CRC);
  assign is_stuff  = stuffable && (run == RUN_W'(STUFF_RUN));
  assign stuff_bad = bit_end && is_stuff && (bit_val == last_bit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run      <= '0;
      last_bit <= 1'b0;
    end else if (state == START) begin
      run <= '0;
    end else if (bit_end && stuffable) begin
      last_bit <= bit_val;
      run <= (is_stuff || (run == '0) || (bit_val != last_bit)) ? RUN_W'(1) : run + RUN_W'(1);
    end
  end
`else
  assign is_stuff  = 1'b0;
  assign stuff_bad = 1'b0;
`endif

  crc8_serial u_crc (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == START),
    .en     (take && ((state == SIZE) || (state == DATA))),
    .bit_in (bit_val),
    .crc    (crc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b0;
      rx_s    <= 1'b0;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bd <= '0; timer <= '0; ones <= '0; bit_cnt <= '0;
      n_size <= '0; byte_cnt <= '0; shreg <= '0; wptr <= '0; rptr <= '0;
      nf <= 1'b0; over <= 1'b0; fe <= 1'b0; crc_err <= 1'b0;
    end else if (state == IDLE) begin
      // The detecting sample is sample 0 of the start bit.
      timer    <= BAUD_W'(1);
      ones     <= {{(BAUD_W-1){1'b0}}, rx_s};
      bd       <= (baudrate < BAUD_MIN) ? BAUD_MIN : baudrate;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      wptr     <= '0;
      rptr     <= '0;
      if (rx_s) begin
        nf <= 1'b0; over <= 1'b0; fe <= 1'b0; crc_err <= 1'b0;
      end
    end else if (state == DELIVER) begin
      if (dr && out_ready) rptr <= rptr + PTR_W'(1);
    end else if (!bit_end) begin
      timer <= timer + BAUD_W'(1);
      ones  <= ones + {{(BAUD_W-1){1'b0}}, rx_s};
    end else begin
      timer <= '0;
      ones  <= '0;
      if (noisy)     nf <= 1'b1;
      if (stuff_bad) fe <= 1'b1;
      if (take) begin
        case (state)
          START: if (!bit_val) nf <= 1'b0;
          SIZE: begin
            n_size  <= size_next;
            bit_cnt <= (bit_cnt == BIT_W'(FS_W - 1)) ? '0 : bit_cnt + BIT_W'(1);
          end
          DATA, CRC: begin
            shreg   <= byte_next;
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_W'(7)) begin
              bit_cnt <= '0;
              if (state == DATA) begin
                byte_cnt <= byte_cnt + FS_W'(1);
                if (wptr == PTR_MAX) over <= 1'b1;
                else                 wptr <= wptr + PTR_W'(1);
              end else begin
                crc_err <= (byte_next != crc);
              end
            end
          end
          STOP:    if (bit_val) fe <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[IDX_W-1:0]] <= byte_next;
  end

  always_comb begin
    state_nx   = state;
    dr         = 1'b0;
    dataout    = 8'h00;
    frame_done = 1'b0;
    case (state)
      IDLE:  if (rx_s) state_nx = START;
      START: if (bit_end) state_nx = bit_val ? SIZE : IDLE;
      SIZE: begin
        if (stuff_bad) state_nx = DELIVER;
        else if (take && (bit_cnt == BIT_W'(FS_W - 1)))
          state_nx = (size_next == '0) ? CRC : DATA;
      end
      DATA: begin
        if (stuff_bad) state_nx = DELIVER;
        else if (byte_end && (byte_cnt == n_size - FS_W'(1))) state_nx = CRC;
      end
      CRC: begin
        if (stuff_bad)     state_nx = DELIVER;
        else if (byte_end) state_nx = STOP;
      end
      STOP: if (bit_end) state_nx = DELIVER;
      DELIVER: begin
        if (fe || crc_err || (rptr == wptr)) begin
          frame_done = 1'b1;
          state_nx   = IDLE;
        end else begin
          dr      = 1'b1;
          dataout = mem[rptr[IDX_W-1:0]];
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_rx_buffered.sv
`default_nettype none
// tb_frame_rx_buffered: directed and randomized frames checked against a frame-level model.
module tb_frame_rx_buffered;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       reset, RX, out_ready;
  logic [7:0] baudrate;
  logic       dr, frame_done, nf, over, fe, crc_err, busy;
  logic [7:0] dataout;

  always #5 clk = ~clk;

  frame_rx_buffered #(
    .MAX_BYTES (MAXB),
    .FS_W      (4),
    .BAUD_W    (8),
    .NOISE_TOL (2),
    .STUFF_RUN (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .RX         (RX),
    .baudrate   (baudrate),
    .out_ready  (out_ready),
    .dr         (dr),
    .dataout    (dataout),
    .frame_done (frame_done),
    .nf         (nf),
    .over       (over),
    .fe         (fe),
    .crc_err    (crc_err),
    .busy       (busy)
  );

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  logic [7:0] got_q[$];
  int         done_cnt = 0;
  logic [3:0] done_flags = 4'h0;

  // Observe handshakes and frame ends away from the active edge.
  always @(negedge clk) begin
    if (dr && out_ready) got_q.push_back(dataout);
    if (frame_done) begin
      done_cnt++;
      done_flags = {nf, over, fe, crc_err};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame description used by the model and the line driver.
  int         f_bd, f_n;
  int         f_flip_bit = -1;
  int         f_flips = 0;
  logic [7:0] f_data[16];
  logic [7:0] f_crcx;
  logic       f_stop;
  logic       bits_q[$];

  task automatic build_bits();
    logic       msg[$];
    logic [7:0] c;
    logic [7:0] rc;
    logic [3:0] nsz;
    msg = {};
    nsz = 4'(f_n);
    for (int i = 3; i >= 0; i--) msg.push_back(nsz[i]);
    for (int k = 0; k < f_n; k++)
      for (int b = 7; b >= 0; b--) msg.push_back(f_data[k][b]);
    c = 8'h00;
    foreach (msg[i]) c = (c[7] ^ msg[i]) ? ((c << 1) ^ 8'h07) : (c << 1);
    rc = c ^ f_crcx;
    bits_q = {};
    bits_q.push_back(1'b1);
    foreach (msg[i]) bits_q.push_back(msg[i]);
    for (int b = 7; b >= 0; b--) bits_q.push_back(rc[b]);
    bits_q.push_back(f_stop);
  endtask

  task automatic send_bits(input int nbits);
    int eff;
    eff = (f_bd < 3) ? 3 : f_bd;
    for (int i = 0; i < nbits; i++) begin
      for (int s = 0; s < eff; s++) begin
        RX = (i == f_flip_bit && s < f_flips) ? ~bits_q[i] : bits_q[i];
        @(posedge clk); #1;
      end
    end
    RX = 1'b0;
  endtask

  task automatic wait_done(input int prev, input bit rand_ready);
    int k;
    k = 0;
    while (done_cnt == prev && k < 3000) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      k++;
    end
    chk("frame_done_seen", done_cnt, prev + 1);
  endtask

  task automatic check_frame(input string nm, input logic exp_nf);
    int   nexp;
    logic good;
    good = (f_crcx == 8'h00) && !f_stop;
    nexp = good ? ((f_n < MAXB) ? f_n : MAXB) : 0;
    chk({nm, "_count"}, got_q.size(), nexp);
    for (int i = 0; i < nexp && i < got_q.size(); i++) chk({nm, "_byte"}, got_q[i], f_data[i]);
    chk({nm, "_flags"}, done_flags, {exp_nf, (f_n > MAXB), f_stop, (f_crcx != 8'h00)});
    got_q = {};
  endtask

  task automatic run_frame(input string nm, input logic exp_nf, input bit rand_ready);
    int prev;
    build_bits();
    baudrate = 8'(f_bd);
    got_q    = {};
    prev     = done_cnt;
    send_bits(bits_q.size());
    wait_done(prev, rand_ready);
    out_ready = 1'b1;
    check_frame(nm, exp_nf);
  endtask

  task automatic setup_case1();
    f_bd = 8; f_n = 2; f_data[0] = 8'hA5; f_data[1] = 8'h3C;
    f_crcx = 8'h00; f_stop = 1'b0; f_flip_bit = -1; f_flips = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int prev;
    reset = 1'b1; RX = 1'b0; out_ready = 1'b1; baudrate = 8'd8;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_dr", dr, 0);           chk("rst_dataout", dataout, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_nf", nf, 0);           chk("rst_over", over, 0);
    chk("rst_fe", fe, 0);           chk("rst_crc_err", crc_err, 0);
    chk("rst_busy", busy, 0);

    setup_case1();
    run_frame("case1", 1'b0, 1'b0);

    f_bd = 16; f_flip_bit = 7; f_flips = 2;
    run_frame("noise2", 1'b0, 1'b0);
    f_flips = 3;
    run_frame("noise3", 1'b1, 1'b0);

    setup_case1();
    f_n = 1; f_data[0] = 8'h5A; f_crcx = 8'h01;
    run_frame("crc_bad", 1'b0, 1'b0);

    setup_case1();
    f_n = 6;
    for (int k = 0; k < 6; k++) f_data[k] = 8'(k + 1);
    run_frame("overflow", 1'b0, 1'b0);

    setup_case1();
    f_stop = 1'b1;
    run_frame("stop_bad", 1'b0, 1'b0);

    setup_case1();
    f_n = 0;
    run_frame("empty", 1'b0, 1'b0);

    // Consumer stalls: the first byte must stay presented.
    setup_case1();
    build_bits();
    baudrate  = 8'(f_bd);
    got_q     = {};
    out_ready = 1'b0;
    prev      = done_cnt;
    send_bits(bits_q.size());
    for (int k = 0; k < 100 && !dr; k++) begin
      @(posedge clk); #1;
    end
    chk("hold_dr_seen", dr, 1);
    for (int k = 0; k < 10; k++) begin
      chk("hold_dr", dr, 1);
      chk("hold_dataout", dataout, 8'hA5);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_done(prev, 1'b0);
    check_frame("hold", 1'b0);

    // Short glitch decodes as a false start.
    baudrate = 8'd8;
    prev = done_cnt;
    RX = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    RX = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("false_start_busy", busy, 1);
    repeat (30) begin @(posedge clk); #1; end
    chk("false_start_no_done", done_cnt, prev);
    chk("false_start_idle", busy, 0);

    // Reset while receiving the first data byte.
    setup_case1();
    build_bits();
    baudrate = 8'(f_bd);
    prev = done_cnt;
    send_bits(9);
    reset = 1'b1;
    #1;
    chk("midrst_outs", {dr, frame_done, nf, over, fe, crc_err, busy}, 0);
    chk("midrst_dataout", dataout, 0);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    chk("midrst_no_done", done_cnt, prev);
    chk("midrst_idle", busy, 0);
    got_q = {};
    setup_case1();
    run_frame("after_rst", 1'b0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      f_bd = $urandom_range(2, 12);
      f_n  = $urandom_range(0, 6);
      for (int k = 0; k < 16; k++) f_data[k] = 8'($urandom);
      f_crcx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      f_stop = ($urandom_range(0, 4) == 0);
      f_flip_bit = -1; f_flips = 0;
      run_frame("rand", 1'b0, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
